// File: rtl/pc_if.sv
// Request/response bundle between the control unit (master) and the PC unit (slave).
interface pc_if #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned OFF_W  = 12
);
  logic              stall;
  logic              write;
  logic              PC_INC;
  logic              branch;
  logic [OFF_W-1:0]  br_off;
  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] ins_in;
  logic [ADDR_W-1:0] ins_out;
  logic              ras_full;
  logic              ras_empty;
  logic              ras_ovf;
  logic              ras_unf;

  modport master (
    output stall, write, PC_INC, branch, br_off, call, ret, ins_in,
    input  ins_out, ras_full, ras_empty, ras_ovf, ras_unf
  );

  modport slave (
    input  stall, write, PC_INC, branch, br_off, call, ret, ins_in,
    output ins_out, ras_full, ras_empty, ras_ovf, ras_unf
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter with relative branch, stall and call/return stack.
// Return-address stack is built only when PC_RAS_EN is defined.
module pc_unit #(
  parameter int unsigned            ADDR_W     = 24,
  parameter logic [ADDR_W-1:0]      RESET_ADDR = '0,
  parameter int unsigned            STEP       = 1,
  parameter int unsigned            OFF_W      = 12,
  parameter int unsigned            RAS_DEPTH  = 4
) (
  input logic clk,
  input logic rst_n,
  pc_if.slave bus
);

  localparam logic [ADDR_W-1:0] StepW = ADDR_W'(STEP);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_next_seq, br_target;
  logic              unf_q, unf_d;

  assign pc_next_seq = pc_q + StepW;
  assign br_target   = pc_q + {{(ADDR_W-OFF_W){bus.br_off[OFF_W-1]}}, bus.br_off};
  assign bus.ins_out = pc_q;
  assign bus.ras_unf = unf_q;

`ifdef PC_RAS_EN
  localparam int unsigned     PtrW   = $clog2(RAS_DEPTH);
  localparam int unsigned     CntW   = PtrW + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(RAS_DEPTH);

  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [PtrW-1:0]   top_q, top_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              push;

  always_comb begin
    pc_d  = pc_q;
    top_d = top_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    if (!bus.stall) begin
      if (bus.write) begin
        pc_d = bus.ins_in;
      end else if (bus.ret) begin
        if (cnt_q == '0) begin
          unf_d = 1'b1;
        end else begin
          pc_d  = ras_q[top_q];
          top_d = top_q - PtrW'(1);
          cnt_d = cnt_q - CntW'(1);
        end
      end else if (bus.call) begin
        // When full, top+1 lands on the oldest entry, so it is overwritten.
        pc_d  = bus.ins_in;
        push  = 1'b1;
        top_d = top_q + PtrW'(1);
        if (cnt_q == CntMax) ovf_d = 1'b1;
        else                 cnt_d = cnt_q + CntW'(1);
      end else if (bus.branch) begin
        pc_d = br_target;
      end else if (bus.PC_INC) begin
        pc_d = pc_next_seq;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_ADDR;
      top_q <= '1;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) ras_q[top_d] <= pc_next_seq;
  end

  assign bus.ras_full  = (cnt_q == CntMax);
  assign bus.ras_empty = (cnt_q == '0);
  assign bus.ras_ovf   = ovf_q;
`else
  always_comb begin
    pc_d  = pc_q;
    unf_d = unf_q;
    if (!bus.stall) begin
      if (bus.write) begin
        pc_d = bus.ins_in;
      end else if (bus.ret) begin
        // No stack: a return is unsupported, flag it and hold.
        unf_d = 1'b1;
      end else if (bus.call) begin
        pc_d = bus.ins_in;
      end else if (bus.branch) begin
        pc_d = br_target;
      end else if (bus.PC_INC) begin
        pc_d = pc_next_seq;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_ADDR;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      unf_q <= unf_d;
    end
  end

  assign bus.ras_full  = 1'b0;
  assign bus.ras_empty = 1'b1;
  assign bus.ras_ovf   = 1'b0;
`endif

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit; successor to the fixed 24-bit PC.
- Drives the instruction-memory address and accepts absolute loads from the C bus.
- Adds: configurable width, step and reset vector; signed relative branch; stall; call/return with a hardware return-address stack (RAS) and sticky error flags.
- Sits between the control unit and IMEM.

Parameters:
- ADDR_W, 24, PC / address width in bits
- RESET_ADDR, 0, PC value loaded on reset
- STEP, 1, increment added by inc and used to form the call return address
- OFF_W, 12, width of the signed branch offset
- RAS_DEPTH, 4, number of return-address entries (power of 2, >=2)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  freeze PC and RAS this cycle
- write  in  1  load PC from ins_in (absolute jump)
- PC_INC  in  1  PC <= PC + STEP
- branch  in  1  PC <= PC + sext(br_off)
- br_off  in  OFF_W  signed two's-complement branch offset
- call  in  1  push PC+STEP onto RAS, PC <= ins_in
- ret  in  1  pop RAS top into PC
- ins_in  in  ADDR_W  C bus to PC (load / call target)
- ins_out  out  ADDR_W  PC to IMEM; equals the register (no comb path from inputs)
- ras_full  out  1  RAS holds RAS_DEPTH entries
- ras_empty  out  1  RAS holds 0 entries
- ras_ovf  out  1  sticky: call while full
- ras_unf  out  1  sticky: ret while empty

Behaviour:
- Reset (async, rst_n=0):
  - PC=RESET_ADDR, RAS count=0, ras_empty=1, ras_full=0, ras_ovf=0, ras_unf=0.
  - Takes effect immediately, mid-operation included.
  - Release is synchronous to clk; the first update is on the first rising edge with rst_n=1.
- All updates occur on posedge clk; ins_out reflects the new PC one cycle after the request (latency 1).
- Per-cycle priority, exactly one action per edge: stall > write > ret > call > branch > PC_INC > hold.
  - write and PC_INC together: write wins. This is a deliberate change from the old PC, where inc won.
- stall=1: PC, RAS, count and flags all hold; every other request is ignored (not queued).
- Arithmetic is modulo 2^ADDR_W; all wrap-arounds are silent.
  - PC = 2^ADDR_W-STEP with PC_INC gives 0.
  - Branch offset is sign-extended to ADDR_W before the add.
  - Negative branch below 0 wraps.
- call:
  - Pushes (PC+STEP) mod 2^ADDR_W; PC <= ins_in; count+1.
  - If full: the oldest entry is overwritten (circular), count stays RAS_DEPTH, ras_ovf <= 1. PC is still loaded.
- ret:
  - If non-empty: PC <= top; count-1.
  - If empty: PC holds, count stays 0, ras_unf <= 1.
- ras_ovf and ras_unf clear only on reset.
- ras_full = (count==RAS_DEPTH); ras_empty = (count==0). Both are registered-state derived and update in the same edge as count.
- RAS is a circular buffer with a top pointer; pop returns entries in LIFO order, including after overflow wrap. After N>DEPTH calls, DEPTH rets return the most recent DEPTH addresses.

Optional Feature:
- Macro PC_RAS_EN.
- Defined: RAS and call/ret behave as above.
- Undefined:
  - No RAS storage.
  - call behaves as write (PC <= ins_in, nothing pushed).
  - ret behaves as hold.
  - ras_full=0 and ras_empty=1 constant; ras_ovf=0 constant.
  - ras_unf is set by any ret (flags that software used an unsupported return).

Test Plan:
- Reset: rst_n=0 mid-run with PC=0x00_1234, RESET_ADDR=0 -> ins_out=0 immediately (before clock edge); ras_empty=1; flags 0.
- Increment/wrap: PC=0xFF_FFFF, PC_INC=1 -> 0x00_0000 next edge. Simultaneous write=1, ins_in=0x00_0040, PC_INC=1 -> 0x00_0040.
- Branch: PC=0x00_0100, br_off=-4 (0xFFC) -> 0x00_00FC; PC=0x000002, br_off=-4 -> 0xFF_FFFE.
- Call/ret LIFO: PC=0x10, call to 0x200, then at 0x200 call to 0x300, ret, ret -> PC sequence 0x200, 0x300, 0x201, 0x11; ras_empty=1 at end.
- Overflow/underflow (DEPTH=4): 5 calls -> ras_full=1, ras_ovf=1; 4 rets return 5th..2nd return addresses; 5th ret -> PC holds, ras_unf=1.
- Stall: stall=1 with write=1 and call=1 -> PC, count, flags unchanged; deassert -> normal priority resumes next edge.
